i2c_txn_framer: RTL

//  Sits between an i2c_listen sniffer and pmic_core. It consumes decoded 9-bit I2C bytes

---
 rtl/i2c_txn_framer.sv | 98 +++++++++
 1 files changed

// File: rtl/i2c_txn_framer.sv
// Frames decoded I2C bytes from the bus sniffer into register-level transactions
// (device, R/W, register pointer, data) for the PMIC core.
module i2c_txn_framer #(
    parameter logic [6:0] DEV_ADDR = 7'h4A,
    parameter bit         FILTER   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] byte_in,
    input  logic       byte_ready,
    input  logic       sop,
    input  logic       eot,
    output logic       txn_valid,
    output logic       txn_rw,
    output logic [6:0] txn_dev,
    output logic [7:0] txn_reg,
    output logic [7:0] txn_data,
    output logic       nack_seen,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        REG   = 3'd2,
        WDATA = 3'd3,
        RDATA = 3'd4,
        SKIP  = 3'd5
    } state_t;

    state_t     state;
    logic [7:0] ptr;
    logic [6:0] dev;

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= 8'd0;
            dev       <= 7'd0;
            txn_valid <= 1'b0;
            txn_rw    <= 1'b0;
            txn_dev   <= 7'd0;
            txn_reg   <= 8'd0;
            txn_data  <= 8'd0;
            nack_seen <= 1'b0;
        end else begin
            txn_valid <= 1'b0;
            if (sop) begin
                // START wins over any byte in the same cycle
                state     <= ADDR;
                nack_seen <= 1'b0;
            end else begin
                if (byte_ready) begin
                    case (state)
                        ADDR: begin
                            if (byte_in[0]) begin
                                state     <= SKIP;
                                nack_seen <= 1'b1;
                            end else if (FILTER && (byte_in[8:2] != DEV_ADDR)) begin
                                state <= SKIP;
                            end else begin
                                dev   <= byte_in[8:2];
                                state <= byte_in[1] ? RDATA : REG;
                            end
                        end
                        REG: begin
                            ptr <= byte_in[8:1];
                            if (byte_in[0]) begin
                                state     <= SKIP;
                                nack_seen <= 1'b1;
                            end else begin
                                state <= WDATA;
                            end
                        end
                        WDATA, RDATA: begin
                            txn_valid <= 1'b1;
                            txn_rw    <= (state == RDATA);
                            txn_dev   <= dev;
                            txn_reg   <= ptr;
                            txn_data  <= byte_in[8:1];
                            ptr       <= ptr + 8'd1;
                            // a master NACK on read data is the normal last byte
                            if (state == WDATA && byte_in[0])
                                state <= SKIP;
                        end
                        default: ;
                    endcase
                end
                // STOP overrides the byte's next state but keeps its side effects
                if (eot)
                    state <= IDLE;
            end
        end
    end

endmodule
